// File: rtl/vga_timing_ctrl_if.sv
// Pixel-source bus: the timing controller requests a coordinate and the source
// returns colour PIX_LAT cycles later.
interface vga_timing_ctrl_if #(
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned COLOR_W = 10
);
    logic                   px_req;
    logic [CNT_W-1:0]       px_h;
    logic [CNT_W-1:0]       px_v;
    logic [3*COLOR_W-1:0]   px_data;

    modport master (output px_req, output px_h, output px_v, input px_data);
    modport slave  (input px_req, input px_h, input px_v, output px_data);
endinterface

// File: rtl/vga_timing_ctrl.sv
// Two-mode VGA timing generator; sync/DE/frame_start and colour leave through a
// PIX_LAT+1 deep pipeline so colour from a latent pixel source lines up with DE.
module vga_timing_ctrl #(
    parameter int unsigned CNT_W   = 11,
    parameter int unsigned COLOR_W = 10,
    parameter int unsigned PIX_LAT = 1,
    parameter int unsigned H0_DATA = 640,
    parameter int unsigned H0_FP   = 16,
    parameter int unsigned H0_PW   = 96,
    parameter int unsigned H0_BP   = 48,
    parameter int unsigned V0_DATA = 480,
    parameter int unsigned V0_FP   = 10,
    parameter int unsigned V0_PW   = 2,
    parameter int unsigned V0_BP   = 33,
    parameter bit          HS0_POL = 1'b0,
    parameter bit          VS0_POL = 1'b0,
    parameter int unsigned H1_DATA = 800,
    parameter int unsigned H1_FP   = 40,
    parameter int unsigned H1_PW   = 128,
    parameter int unsigned H1_BP   = 88,
    parameter int unsigned V1_DATA = 600,
    parameter int unsigned V1_FP   = 1,
    parameter int unsigned V1_PW   = 4,
    parameter int unsigned V1_BP   = 23,
    parameter bit          HS1_POL = 1'b1,
    parameter bit          VS1_POL = 1'b1
) (
    input  logic                px_clk,
    input  logic                rst,
    input  logic                mode,
    vga_timing_ctrl_if.master   px_bus,
    output logic [COLOR_W-1:0]  RED,
    output logic [COLOR_W-1:0]  GRN,
    output logic [COLOR_W-1:0]  BLU,
    output logic                HSYNC,
    output logic                VSYNC,
    output logic                DE,
    output logic                frame_start
);

    localparam int unsigned H0_TOT = H0_DATA + H0_FP + H0_PW + H0_BP;
    localparam int unsigned V0_TOT = V0_DATA + V0_FP + V0_PW + V0_BP;
    localparam int unsigned H1_TOT = H1_DATA + H1_FP + H1_PW + H1_BP;
    localparam int unsigned V1_TOT = V1_DATA + V1_FP + V1_PW + V1_BP;
    localparam longint unsigned CNT_RANGE = 64'd1 << CNT_W;

    localparam bit TOT_OK = (H0_TOT <= CNT_RANGE) && (V0_TOT <= CNT_RANGE) &&
                            (H1_TOT <= CNT_RANGE) && (V1_TOT <= CNT_RANGE);
    localparam bit PORCH_OK = (H0_FP != 0) && (H0_PW != 0) && (H0_BP != 0) &&
                              (V0_FP != 0) && (V0_PW != 0) && (V0_BP != 0) &&
                              (H1_FP != 0) && (H1_PW != 0) && (H1_BP != 0) &&
                              (V1_FP != 0) && (V1_PW != 0) && (V1_BP != 0);

    if (!TOT_OK || !PORCH_OK || PIX_LAT > 7) begin : g_bad_params
        $error("vga_timing_ctrl: illegal timing parameter set");
    end

    // Per-mode compare points; sync windows are inclusive [beg, end].
    localparam logic [CNT_W-1:0] H0_DAT = CNT_W'(H0_DATA);
    localparam logic [CNT_W-1:0] H0_BEG = CNT_W'(H0_DATA + H0_FP);
    localparam logic [CNT_W-1:0] H0_END = CNT_W'(H0_DATA + H0_FP + H0_PW - 1);
    localparam logic [CNT_W-1:0] H0_LST = CNT_W'(H0_TOT - 1);
    localparam logic [CNT_W-1:0] V0_DAT = CNT_W'(V0_DATA);
    localparam logic [CNT_W-1:0] V0_BEG = CNT_W'(V0_DATA + V0_FP);
    localparam logic [CNT_W-1:0] V0_END = CNT_W'(V0_DATA + V0_FP + V0_PW - 1);
    localparam logic [CNT_W-1:0] V0_LST = CNT_W'(V0_TOT - 1);
    localparam logic [CNT_W-1:0] H1_DAT = CNT_W'(H1_DATA);
    localparam logic [CNT_W-1:0] H1_BEG = CNT_W'(H1_DATA + H1_FP);
    localparam logic [CNT_W-1:0] H1_END = CNT_W'(H1_DATA + H1_FP + H1_PW - 1);
    localparam logic [CNT_W-1:0] H1_LST = CNT_W'(H1_TOT - 1);
    localparam logic [CNT_W-1:0] V1_DAT = CNT_W'(V1_DATA);
    localparam logic [CNT_W-1:0] V1_BEG = CNT_W'(V1_DATA + V1_FP);
    localparam logic [CNT_W-1:0] V1_END = CNT_W'(V1_DATA + V1_FP + V1_PW - 1);
    localparam logic [CNT_W-1:0] V1_LST = CNT_W'(V1_TOT - 1);

    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic             mode_q, mode_d;

    logic [CNT_W-1:0] h_dat, h_beg, h_end, h_lst, v_dat, v_beg, v_end, v_lst;
    logic             hs_pol, vs_pol;
    logic             visible, hs_raw, vs_raw, fs_raw;

    logic [PIX_LAT:0]   hs_q, vs_q, de_q, fs_q;
    logic [PIX_LAT+1:0] hs_tap, vs_tap, de_tap, fs_tap;
    logic [3*COLOR_W-1:0] rgb_q, rgb_d;

    always_comb begin
        h_dat  = mode_q ? H1_DAT : H0_DAT;
        h_beg  = mode_q ? H1_BEG : H0_BEG;
        h_end  = mode_q ? H1_END : H0_END;
        h_lst  = mode_q ? H1_LST : H0_LST;
        v_dat  = mode_q ? V1_DAT : V0_DAT;
        v_beg  = mode_q ? V1_BEG : V0_BEG;
        v_end  = mode_q ? V1_END : V0_END;
        v_lst  = mode_q ? V1_LST : V0_LST;
        hs_pol = mode_q ? HS1_POL : HS0_POL;
        vs_pol = mode_q ? VS1_POL : VS0_POL;
    end

    always_comb begin
        visible = (hcnt_q < h_dat) && (vcnt_q < v_dat);
        hs_raw  = ((hcnt_q >= h_beg) && (hcnt_q <= h_end)) ? hs_pol : ~hs_pol;
        vs_raw  = ((vcnt_q >= v_beg) && (vcnt_q <= v_end)) ? vs_pol : ~vs_pol;
        fs_raw  = (hcnt_q == '0) && (vcnt_q == '0);
        px_bus.px_req = visible;
        px_bus.px_h   = visible ? hcnt_q : '0;
        px_bus.px_v   = visible ? vcnt_q : '0;
    end

    // Mode is only taken at the frame boundary so a frame never mixes timings.
    always_comb begin
        hcnt_d = hcnt_q + CNT_W'(1);
        vcnt_d = vcnt_q;
        mode_d = mode_q;
        if (hcnt_q == h_lst) begin
            hcnt_d = '0;
            if (vcnt_q == v_lst) begin
                vcnt_d = '0;
                mode_d = mode;
            end else begin
                vcnt_d = vcnt_q + CNT_W'(1);
            end
        end
    end

    // Tap 0 is the raw value, tap k+1 is pipeline stage k.
    always_comb begin
        hs_tap = {hs_q, hs_raw};
        vs_tap = {vs_q, vs_raw};
        de_tap = {de_q, visible};
        fs_tap = {fs_q, fs_raw};
        rgb_d  = de_tap[PIX_LAT] ? px_bus.px_data : '0;
    end

    always_ff @(posedge px_clk) begin
        if (rst) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            mode_q <= 1'b0;
            hs_q   <= {(PIX_LAT+1){~HS0_POL}};
            vs_q   <= {(PIX_LAT+1){~VS0_POL}};
            de_q   <= '0;
            fs_q   <= '0;
            rgb_q  <= '0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            mode_q <= mode_d;
            hs_q   <= hs_tap[PIX_LAT:0];
            vs_q   <= vs_tap[PIX_LAT:0];
            de_q   <= de_tap[PIX_LAT:0];
            fs_q   <= fs_tap[PIX_LAT:0];
            rgb_q  <= rgb_d;
        end
    end

    always_comb begin
        HSYNC       = hs_tap[PIX_LAT+1];
        VSYNC       = vs_tap[PIX_LAT+1];
        DE          = de_tap[PIX_LAT+1];
        frame_start = fs_tap[PIX_LAT+1];
        RED         = rgb_q[3*COLOR_W-1 -: COLOR_W];
        GRN         = rgb_q[2*COLOR_W-1 -: COLOR_W];
        BLU         = rgb_q[COLOR_W-1:0];
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Randomized bench for vga_timing_ctrl: small timings, PIX_LAT=3, compared each
// cycle against a screen-position model with a latency queue.
module tb_vga_timing_ctrl;

    localparam int unsigned NW  = 6;
    localparam int unsigned CW  = 6;
    localparam int unsigned LAT = 3;
    localparam int H0D = 16, H0F = 2, H0P = 4, H0B = 3;
    localparam int V0D = 12, V0F = 2, V0P = 2, V0B = 3;
    localparam int H1D = 20, H1F = 3, H1P = 5, H1B = 2;
    localparam int V1D = 10, V1F = 1, V1P = 3, V1B = 2;
    localparam bit HP0 = 1'b0, VP0 = 1'b0, HP1 = 1'b1, VP1 = 1'b1;

    typedef struct packed {
        logic hs;
        logic vs;
        logic de;
        logic fs;
        logic [3*CW-1:0] rgb;
    } out_t;

    logic px_clk = 1'b0;
    logic rst = 1'b1;
    logic mode = 1'b0;
    logic [CW-1:0] red, grn, blu;
    logic hsync, vsync, de, fs;

    vga_timing_ctrl_if #(.CNT_W(NW), .COLOR_W(CW)) px_bus ();

    vga_timing_ctrl #(
        .CNT_W(NW), .COLOR_W(CW), .PIX_LAT(LAT),
        .H0_DATA(H0D), .H0_FP(H0F), .H0_PW(H0P), .H0_BP(H0B),
        .V0_DATA(V0D), .V0_FP(V0F), .V0_PW(V0P), .V0_BP(V0B),
        .HS0_POL(HP0), .VS0_POL(VP0),
        .H1_DATA(H1D), .H1_FP(H1F), .H1_PW(H1P), .H1_BP(H1B),
        .V1_DATA(V1D), .V1_FP(V1F), .V1_PW(V1P), .V1_BP(V1B),
        .HS1_POL(HP1), .VS1_POL(VP1)
    ) dut (
        .px_clk(px_clk), .rst(rst), .mode(mode), .px_bus(px_bus),
        .RED(red), .GRN(grn), .BLU(blu),
        .HSYNC(hsync), .VSYNC(vsync), .DE(de), .frame_start(fs)
    );

    always #5 px_clk = ~px_clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: screen position and timing set of the current cycle.
    int   mx = 0, my = 0;
    bit   mmode = 1'b0;
    out_t hist[$];
    logic [3*CW-1:0] dq[$];
    bit   mode_r = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void timing(output int hd, output int hf, output int hp, output int ht,
                                   output int vd, output int vf, output int vp, output int vt,
                                   output bit hpol, output bit vpol);
        hd = mmode ? H1D : H0D;  hf = mmode ? H1F : H0F;  hp = mmode ? H1P : H0P;
        ht = mmode ? H1D + H1F + H1P + H1B : H0D + H0F + H0P + H0B;
        vd = mmode ? V1D : V0D;  vf = mmode ? V1F : V0F;  vp = mmode ? V1P : V0P;
        vt = mmode ? V1D + V1F + V1P + V1B : V0D + V0F + V0P + V0B;
        hpol = mmode ? HP1 : HP0;
        vpol = mmode ? VP1 : VP0;
    endfunction

    function automatic bit model_visible();
        int hd, hf, hp, ht, vd, vf, vp, vt;
        bit hpol, vpol;
        timing(hd, hf, hp, ht, vd, vf, vp, vt, hpol, vpol);
        return (mx < hd) && (my < vd);
    endfunction

    function automatic out_t raw_out();
        int hd, hf, hp, ht, vd, vf, vp, vt;
        bit hpol, vpol;
        out_t o;
        timing(hd, hf, hp, ht, vd, vf, vp, vt, hpol, vpol);
        o.hs  = (mx >= hd + hf && mx < hd + hf + hp) ? hpol : !hpol;
        o.vs  = (my >= vd + vf && my < vd + vf + vp) ? vpol : !vpol;
        o.de  = (mx < hd) && (my < vd);
        o.fs  = (mx == 0) && (my == 0);
        o.rgb = o.de ? {CW'(mx), CW'(my), CW'(mx ^ my)} : '0;
        return o;
    endfunction

    task automatic step(input bit r, input bit m);
        int hd, hf, hp, ht, vd, vf, vp, vt;
        bit hpol, vpol, vis;
        out_t e, idle;
        logic [3*CW-1:0] d;
        rst  = r;
        mode = m;
        @(posedge px_clk);
        if (r) begin
            mx = 0; my = 0; mmode = 1'b0;
            idle = '{hs: !HP0, vs: !VP0, de: 1'b0, fs: 1'b0, rgb: '0};
            hist.delete();
            for (int i = 0; i <= LAT; i++) hist.push_back(idle);
        end else begin
            hist.push_back(raw_out());
            void'(hist.pop_front());
            timing(hd, hf, hp, ht, vd, vf, vp, vt, hpol, vpol);
            if (mx == ht - 1) begin
                mx = 0;
                if (my == vt - 1) begin
                    my = 0;
                    mmode = m;
                end else begin
                    my++;
                end
            end else begin
                mx++;
            end
        end
        #1;
        e   = hist[0];
        vis = model_visible();
        check("px_req", px_bus.px_req, vis);
        check("px_h", px_bus.px_h, vis ? NW'(mx) : '0);
        check("px_v", px_bus.px_v, vis ? NW'(my) : '0);
        check("hsync", hsync, e.hs);
        check("vsync", vsync, e.vs);
        check("de", de, e.de);
        check("frame_start", fs, e.fs);
        check("rgb", {red, grn, blu}, e.rgb);
        // Pixel source: echo the request coordinates LAT cycles later, junk otherwise.
        if (px_bus.px_req)
            d = {CW'(px_bus.px_h), CW'(px_bus.px_v), CW'(px_bus.px_h ^ px_bus.px_v)};
        else
            d = (3*CW)'($urandom);
        dq.push_back(d);
        px_bus.px_data = dq.pop_front();
    endtask

    initial begin
        px_bus.px_data = '0;
        for (int i = 0; i < LAT; i++) dq.push_back((3*CW)'($urandom));

        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);

        // Mode-0 frame, switch requested mid-frame at line 5.
        for (int i = 0; i < 2000 && my != 5; i++) step(1'b0, 1'b0);
        check("seek_line5", (my == 5), 1'b1);
        mode_r = 1'b1;
        for (int i = 0; i < 1200; i++) step(1'b0, mode_r);

        // Single-cycle reset in the middle of a line.
        for (int i = 0; i < 2000 && !(mx == 10 && my == 7); i++) step(1'b0, mode_r);
        check("seek_mid", (mx == 10 && my == 7), 1'b1);
        step(1'b1, mode_r);
        for (int i = 0; i < 1000; i++) step(1'b0, mode_r);

        for (int i = 0; i < 6000; i++) begin
            if ($urandom_range(199) == 0) mode_r = ~mode_r;
            step(($urandom_range(999) == 0), mode_r);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
